// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-port register file with two falling-edge write ports
// Port 1 wins write collisions; optional write-to-read bypass; optional hardwired zero register.
module regfile_multiport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_RD*AW-1:0]    RA,
  output logic [NUM_RD*WIDTH-1:0] BusR,
  input  logic [AW-1:0]           RW0,
  input  logic [WIDTH-1:0]        BusW0,
  input  logic                    RegWr0,
  input  logic [AW-1:0]           RW1,
  input  logic [WIDTH-1:0]        BusW1,
  input  logic                    RegWr1,
  output logic [DEPTH-1:0]        Written
);

  localparam bit            ZERO_EN   = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [DEPTH-1:0] written_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_EN && (a == ZERO_ADDR);
  endfunction

  // Port 1 is applied last so it overwrites port 0 on an address collision.
  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    if (RegWr0 && !is_zero(RW0)) begin
      mem_d[RW0]     = BusW0;
      written_d[RW0] = 1'b1;
    end
    if (RegWr1 && !is_zero(RW1)) begin
      mem_d[RW1]     = BusW1;
      written_d[RW1] = 1'b1;
    end
  end

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      written_q <= '0;
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
    end
  end

  assign Written = written_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd_data;

    assign addr = RA[k*AW +: AW];

    // Forwarding is suppressed under Reset, since no write can commit then.
    always_comb begin
      rd_data = mem_q[addr];
      if ((BYPASS != 0) && !Reset) begin
        if (RegWr1 && (RW1 == addr)) begin
          rd_data = BusW1;
        end else if (RegWr0 && (RW0 == addr)) begin
          rd_data = BusW0;
        end
      end
      if (is_zero(addr)) begin
        rd_data = '0;
      end
    end

    assign BusR[k*WIDTH +: WIDTH] = rd_data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed checks for regfile_multiport
// Three instances: default bypassing 4-read file, non-bypassing file, narrow file without zero register.
module tb_regfile_multiport;

  logic Clk;
  logic Reset;

  logic [19:0]  ra_m;
  logic [255:0] busr_m;
  logic [4:0]   rw0_m, rw1_m;
  logic [63:0]  bw0_m, bw1_m;
  logic         we0_m, we1_m;
  logic [31:0]  wr_m;

  logic [4:0]   ra_n;
  logic [63:0]  busr_n;
  logic [4:0]   rw0_n, rw1_n;
  logic [63:0]  bw0_n, bw1_n;
  logic         we0_n, we1_n;
  logic [31:0]  wr_n;

  logic [3:0]   ra_s;
  logic [31:0]  busr_s;
  logic [3:0]   rw0_s, rw1_s;
  logic [31:0]  bw0_s, bw1_s;
  logic         we0_s, we1_s;
  logic [15:0]  wr_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  ra;
    logic [63:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [7];

  regfile_multiport #(.WIDTH(64), .DEPTH(32), .NUM_RD(4), .ZERO_REG(31), .BYPASS(1)) u_dut (
    .Clk(Clk), .Reset(Reset), .RA(ra_m), .BusR(busr_m),
    .RW0(rw0_m), .BusW0(bw0_m), .RegWr0(we0_m),
    .RW1(rw1_m), .BusW1(bw1_m), .RegWr1(we1_m), .Written(wr_m)
  );

  regfile_multiport #(.WIDTH(64), .DEPTH(32), .NUM_RD(1), .ZERO_REG(31), .BYPASS(0)) u_nb (
    .Clk(Clk), .Reset(Reset), .RA(ra_n), .BusR(busr_n),
    .RW0(rw0_n), .BusW0(bw0_n), .RegWr0(we0_n),
    .RW1(rw1_n), .BusW1(bw1_n), .RegWr1(we1_n), .Written(wr_n)
  );

  regfile_multiport #(.WIDTH(32), .DEPTH(16), .NUM_RD(1), .ZERO_REG(16), .BYPASS(1)) u_sm (
    .Clk(Clk), .Reset(Reset), .RA(ra_s), .BusR(busr_s),
    .RW0(rw0_s), .BusW0(bw0_s), .RegWr0(we0_s),
    .RW1(rw1_s), .BusW1(bw1_s), .RegWr1(we1_s), .Written(wr_s)
  );

  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic at_high();
    @(posedge Clk);
    #1;
  endtask

  task automatic commit();
    @(negedge Clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{ra: 5'd0,  exp: 64'd0};
    vecs[1] = '{ra: 5'd1,  exp: 64'd1};
    vecs[2] = '{ra: 5'd7,  exp: 64'd7};
    vecs[3] = '{ra: 5'd13, exp: 64'd13};
    vecs[4] = '{ra: 5'd22, exp: 64'd22};
    vecs[5] = '{ra: 5'd30, exp: 64'd30};
    vecs[6] = '{ra: 5'd31, exp: 64'd0};

    Reset = 1'b0;
    ra_m = '0; rw0_m = '0; rw1_m = '0; bw0_m = '0; bw1_m = '0; we0_m = 1'b0; we1_m = 1'b0;
    ra_n = '0; rw0_n = '0; rw1_n = '0; bw0_n = '0; bw1_n = '0; we0_n = 1'b0; we1_n = 1'b0;
    ra_s = '0; rw0_s = '0; rw1_s = '0; bw0_s = '0; bw1_s = '0; we0_s = 1'b0; we1_s = 1'b0;
    #1;

    // Reset with a write pending: nothing commits, nothing forwards.
    Reset = 1'b1;
    we0_m = 1'b1; rw0_m = 5'd5; bw0_m = 64'h12345678;
    ra_m  = {4{5'd5}};
    commit();
    check("rst_bypass_blocked", busr_m[63:0], 64'd0);
    for (int a = 0; a < 32; a++) begin
      ra_m = {4{a[4:0]}};
      #1;
      check($sformatf("rst_read_%0d", a), {63'd0, |busr_m}, 64'd0);
    end
    check("rst_written", {32'd0, wr_m}, 64'd0);

    at_high();
    Reset = 1'b0;
    we0_m = 1'b1; rw0_m = 5'd31; bw0_m = 64'h12345678;
    ra_m  = {4{5'd31}};
    #1;
    check("zero_bypass", busr_m[63:0], 64'd0);
    commit();
    we0_m = 1'b0;
    #1;
    check("zero_read", busr_m[63:0], 64'd0);
    check("zero_written", {32'd0, wr_m}, 64'd0);

    // Fill registers 0..30, alternating write ports.
    for (int i = 0; i < 31; i++) begin
      at_high();
      if (i % 2 == 0) begin
        we0_m = 1'b1; rw0_m = i[4:0]; bw0_m = 64'(i);
      end else begin
        we1_m = 1'b1; rw1_m = i[4:0]; bw1_m = 64'(i);
      end
      commit();
      we0_m = 1'b0;
      we1_m = 1'b0;
    end

    foreach (vecs[v]) begin
      ra_m = {4{vecs[v].ra}};
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("fill_ra%0d_port%0d", vecs[v].ra, k), busr_m[k*64 +: 64], vecs[v].exp);
    end
    ra_m = {5'd3, 5'd2, 5'd1, 5'd0};
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("cross_port%0d", k), busr_m[k*64 +: 64], 64'(k));
    check("fill_written", {32'd0, wr_m}, 64'h7FFFFFFF);

    // Same-address dual write: port 1 wins, both in bypass and in storage.
    at_high();
    we0_m = 1'b1; rw0_m = 5'd13; bw0_m = 64'hAAAA;
    we1_m = 1'b1; rw1_m = 5'd13; bw1_m = 64'hBBBB;
    ra_m  = {4{5'd13}};
    #1;
    check("collide_bypass", busr_m[63:0], 64'hBBBB);
    commit();
    we0_m = 1'b0; we1_m = 1'b0;
    #1;
    check("collide_stored", busr_m[63:0], 64'hBBBB);
    check("collide_written", {32'd0, wr_m}, 64'h7FFFFFFF);

    at_high();
    we0_m = 1'b1; rw0_m = 5'd20; bw0_m = 64'hDEAD_0000_0000_0020;
    we1_m = 1'b1; rw1_m = 5'd21; bw1_m = 64'hBEEF_0000_0000_0021;
    ra_m  = {5'd21, 5'd20, 5'd21, 5'd20};
    #1;
    check("dual_bypass_p0", busr_m[63:0],   64'hDEAD_0000_0000_0020);
    check("dual_bypass_p1", busr_m[127:64], 64'hBEEF_0000_0000_0021);
    commit();
    we0_m = 1'b0; we1_m = 1'b0;
    #1;
    check("dual_stored_p2", busr_m[191:128], 64'hDEAD_0000_0000_0020);
    check("dual_stored_p3", busr_m[255:192], 64'hBEEF_0000_0000_0021);

    at_high();
    rw0_m = 5'd2; bw0_m = 64'h5555;
    ra_m  = {4{5'd2}};
    #1;
    check("disabled_no_forward", busr_m[63:0], 64'd2);

    // Non-bypassing instance: value appears only after the committing edge.
    at_high();
    we0_n = 1'b1; rw0_n = 5'd14; bw0_n = 64'd14;
    commit();
    we0_n = 1'b0;
    at_high();
    ra_n  = 5'd14; rw0_n = 5'd14; bw0_n = 64'h9080009;
    #1;
    check("nb_disabled_before", busr_n, 64'd14);
    commit();
    check("nb_disabled_after", busr_n, 64'd14);
    at_high();
    we0_n = 1'b1;
    #1;
    check("nb_pending_before", busr_n, 64'd14);
    commit();
    check("nb_pending_after", busr_n, 64'h9080009);
    we0_n = 1'b0;
    check("nb_written", {32'd0, wr_n}, 64'h4000);

    // Reset asserted while Clk is high with a write to register 10 pending.
    at_high();
    we0_m = 1'b1; rw0_m = 5'd10; bw0_m = 64'h1010;
    ra_m  = {4{5'd10}};
    commit();
    check("r10_written_value", busr_m[63:0], 64'h1010);
    at_high();
    #1;
    Reset = 1'b1;
    #1;
    check("async_rst_read", busr_m[63:0], 64'd0);
    check("async_rst_written", {32'd0, wr_m}, 64'd0);
    commit();
    check("rst_edge_no_write", busr_m[63:0], 64'd0);
    check("rst_clears_nb", {32'd0, wr_n}, 64'd0);
    at_high();
    Reset = 1'b0;
    we0_m = 1'b0;
    #1;
    check("r10_after_release", busr_m[63:0], 64'd0);

    // Narrow instance with the zero register disabled.
    at_high();
    we0_s = 1'b1; rw0_s = 4'd15; bw0_s = 32'hFFFFFFFF;
    ra_s  = 4'd15;
    commit();
    we0_s = 1'b0;
    #1;
    check("sm_r15_read", {32'd0, busr_s}, 64'hFFFFFFFF);
    check("sm_written", {48'd0, wr_s}, 64'h8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the CPU's 32x64 register file: configurable data width, register count, and number of read ports. It adds a second write port with a defined collision priority, optional write-to-read bypass, an asynchronous clear, and a per-register written-since-reset flag vector. It sits in the decode stage of the datapath, feeding operand buses and accepting results from the writeback and load paths. The hardwired-zero register (XZR) is retained as a parameter.

## Interface
Parameters:
- WIDTH, 64: data width of every register and bus.
- DEPTH, 32: number of registers; power of two, at least 2; AW = log2(DEPTH).
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, DEPTH-1: index that always reads 0 and ignores writes. A value of DEPTH or more disables the feature.
- BYPASS, 1: 1 = a read of an address being written this cycle returns the write data; 0 = the read returns the stored value.

Ports:
- Clk  in  1  clock; register updates occur on the falling edge.
- Reset  in  1  asynchronous, active-high; clears all registers and flags.
- RA  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW].
- BusR  out  NUM_RD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]. Combinational.
- RW0  in  AW  write port 0 address.
- BusW0  in  WIDTH  write port 0 data.
- RegWr0  in  1  write port 0 enable.
- RW1  in  AW  write port 1 address.
- BusW1  in  WIDTH  write port 1 data.
- RegWr1  in  1  write port 1 enable.
- Written  out  DEPTH  bit i is set once register i has been written since reset. Bit ZERO_REG is always 0.

## Operation
- Storage: DEPTH x WIDTH flops.
  - Reset asserted: every register = 0 and Written = 0, immediately, with no clock required.
- Write commit:
  - On each falling edge of Clk with Reset low, each enabled port writes its BusW to its RW.
  - A write to ZERO_REG is discarded and its Written bit stays 0.
- Collision: when both ports are enabled to the same non-zero address, port 1 wins. The stored value is BusW1 and Written is set once.
- Distinct addresses: both ports commit in the same edge.
- Read, per port k:
  - RA_k == ZERO_REG: output 0.
  - Otherwise, if BYPASS=1 and a write port is enabled to RA_k: output that port's BusW. Port 1 takes priority on collision, so the result matches what will be stored.
  - Otherwise: output the stored register.
- Reads are fully combinational and independent across ports. Any number of ports may read the same address.
- Written bits: set on commit; cleared only by Reset.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.

## Timing
- Read latency: 0 cycles (combinational from RA, storage, and bypass inputs).
- Write latency:
  - BYPASS=0: the value is visible on BusR immediately after the falling edge that commits it, i.e. in the second half of the same Clk cycle.
  - BYPASS=1: the value is visible as soon as RegWr, RW, and BusW are stable.
- Setup: RW, BusW, and RegWr must be stable before the falling edge. The rising edge has no effect.
- Reset mid-operation: Reset takes priority over any coincident falling-edge write; no write occurs while Reset is high.
  - Deassertion is asynchronous. The first write after deassertion is the next falling edge.
- Reset values: all registers = 0, BusR = 0 on every port (all addresses read 0), Written = 0.
- Bypass with RegWr low: no forwarding. A disabled port never affects reads.

## Test plan
- Reset and zero register: assert Reset with RegWr0=1, RW0=5, BusW0=h12345678, then toggle Clk. BusR reads 0 at every address and Written = 0. Deassert Reset and write h12345678 to register 31 on port 0. Register 31 still reads 0 and Written[31]=0.
- Fill and readback: write value i to register i for i=0..30 through port 0, alternating with port 1. All four read ports (NUM_RD=4) return i for RA=i. Written = h7FFFFFFF.
- Dual write, same address: RW0=RW1=13 with BusW0=hAAAA, BusW1=hBBBB, both enabled. After the falling edge, register 13 = hBBBB. With BYPASS=1 before the edge, BusR for RA=13 is already hBBBB.
- Bypass off: with BYPASS=0, register 14 = 14, and a write of h9080009 to register 14 is pending. Before the falling edge BusR = 14; after it BusR = h9080009. With RegWr0=0 the register stays 14 and BusR = 14.
- Async reset mid-cycle: write h1010 to register 10 and assert Reset while Clk is high. BusR for RA=10 is 0 before the next edge. A falling edge while Reset is high with RegWr0=1 leaves register 10 = 0.
- Parameter sweep: WIDTH=32, DEPTH=16, NUM_RD=1, ZERO_REG=16 (feature disabled). Write hFFFFFFFF to register 15; it reads hFFFFFFFF and Written[15]=1.
